grey_decade_chain: RTL and testbench

- Parametrised, fully synchronous chain of 5-bit Johnson ("grey") decade digits; DIGITS digits form a decimal counter 0 .. 10^DIGITS-1.
- Successor to the three-digit ripple-clocked decade counter. All digits run on i_clk and advance via carry enables; no derived clocks.
- Adds up/down counting, count enable, synchronous clear and a wrap pulse. Used as the display/event counter behind the ring-oscillator front end.

---
 rtl/grey_pkg.sv | 39 +++
 rtl/grey_decade_digit.sv | 97 +++++++++
 rtl/grey_decade_chain.sv | 87 ++++++++
 tb/tb_grey_decade_chain.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// Shared definitions for the Johnson ("grey") decade digit chain.
// Holds the digit width, the ten legal Johnson codes, the terminal
// codes used by the carry chain and a legality check used by the
// optional GREY_STATE_CHECK_EN state checker.
package grey_pkg;

  // Width of one Johnson decade digit.
  localparam int JOHNSON_W = 5;

  // Johnson codes for the decimal values 0..9.
  localparam logic [JOHNSON_W-1:0] J0 = 5'b00000;
  localparam logic [JOHNSON_W-1:0] J1 = 5'b00001;
  localparam logic [JOHNSON_W-1:0] J2 = 5'b00011;
  localparam logic [JOHNSON_W-1:0] J3 = 5'b00111;
  localparam logic [JOHNSON_W-1:0] J4 = 5'b01111;
  localparam logic [JOHNSON_W-1:0] J5 = 5'b11111;
  localparam logic [JOHNSON_W-1:0] J6 = 5'b11110;
  localparam logic [JOHNSON_W-1:0] J7 = 5'b11100;
  localparam logic [JOHNSON_W-1:0] J8 = 5'b11000;
  localparam logic [JOHNSON_W-1:0] J9 = 5'b10000;

  // A digit passes a carry upward when it sits at one of these codes.
  // 9 is the terminal value when counting up and 0 when counting down.
  localparam logic [JOHNSON_W-1:0] J_TERM_UP = J9;
  localparam logic [JOHNSON_W-1:0] J_TERM_DN = J0;

  // Returns 1 when the code is one of the ten legal Johnson codes.
  // The other 22 five-bit patterns can only come from an upset.
  function automatic logic johnson_legal(input logic [JOHNSON_W-1:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      J0, J1, J2, J3, J4, J5, J6, J7, J8, J9: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/grey_decade_digit.sv
// One 5-bit Johnson decade digit of grey_decade_chain.
// The digit shifts left (with the top bit inverted into bit 0) to count
// up, and shifts right (with bit 0 inverted into bit 4) to count down.
// A step only happens when i_step is high; i_clr forces the digit to 0.
// With GREY_STATE_CHECK_EN defined an illegal code is forced back to 0
// on the next edge and o_err flags the correction for one cycle.
module grey_decade_digit
  import grey_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_step,
  input  logic                 i_up,
  output logic [JOHNSON_W-1:0] o_q,
  output logic                 o_term_up,
`ifdef GREY_STATE_CHECK_EN
  output logic                 o_term_dn,
  output logic                 o_err
`else
  output logic                 o_term_dn
`endif
);

  logic [JOHNSON_W-1:0] q_q;
  logic [JOHNSON_W-1:0] q_d;
  logic [JOHNSON_W-1:0] q_inc;
  logic [JOHNSON_W-1:0] q_dec;

`ifdef GREY_STATE_CHECK_EN
  logic illegal;
  logic err_q;
  logic err_d;
`endif

  // Both neighbouring codes of the current digit; each differs in one bit.
  always_comb begin
    q_inc = {q_q[JOHNSON_W-2:0], ~q_q[JOHNSON_W-1]};
    q_dec = {~q_q[0], q_q[JOHNSON_W-1:1]};
  end

`ifdef GREY_STATE_CHECK_EN
  // Next digit value: clear first, then repair of an illegal code, then a step.
  always_comb begin
    illegal = ~johnson_legal(q_q);
    q_d     = q_q;
    err_d   = 1'b0;
    if (i_clr) begin
      q_d = J0;
    end else if (illegal) begin
      q_d   = J0;
      err_d = 1'b1;
    end else if (i_step) begin
      q_d = i_up ? q_inc : q_dec;
    end
  end
`else
  // Next digit value: clear first, otherwise step in the selected direction.
  always_comb begin
    q_d = q_q;
    if (i_clr) begin
      q_d = J0;
    end else if (i_step) begin
      q_d = i_up ? q_inc : q_dec;
    end
  end
`endif

`ifdef GREY_STATE_CHECK_EN
  // Digit and correction flag registers, synchronously reset to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q   <= J0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  // Digit register, synchronously reset to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q <= J0;
    end else begin
      q_q <= q_d;
    end
  end
`endif

  assign o_q       = q_q;
  assign o_term_up = (q_q == J_TERM_UP);
  assign o_term_dn = (q_q == J_TERM_DN);

endmodule

// File: rtl/grey_decade_chain.sv
// Fully synchronous chain of DIGITS Johnson decade digits forming a
// decimal up/down counter 0 .. 10^DIGITS-1. Every digit runs on i_clk;
// higher digits advance through a combinational carry-enable chain so
// the whole count updates on a single edge. o_wrap pulses for one cycle
// when the full chain rolls over (all 9s -> all 0s up, or the reverse).
// Optional feature macro: GREY_STATE_CHECK_EN adds per-digit illegal
// code repair and the registered o_err output.
module grey_decade_chain
  import grey_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_up,
  input  logic                          i_clr,
  output logic [JOHNSON_W*DIGITS-1:0]   o_cnt,
`ifdef GREY_STATE_CHECK_EN
  output logic                          o_wrap,
  output logic                          o_err
`else
  output logic                          o_wrap
`endif
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] term_up;
  logic [DIGITS-1:0] term_dn;
  logic [DIGITS-1:0] term_sel;
  logic              wrap_q;
  logic              wrap_d;

`ifdef GREY_STATE_CHECK_EN
  logic [DIGITS-1:0] err;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : gen_digit
    grey_decade_digit u_digit (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (i_clr),
      .i_step    (step[k]),
      .i_up      (i_up),
      .o_q       (o_cnt[JOHNSON_W*k +: JOHNSON_W]),
      .o_term_up (term_up[k]),
`ifdef GREY_STATE_CHECK_EN
      .o_term_dn (term_dn[k]),
      .o_err     (err[k])
`else
      .o_term_dn (term_dn[k])
`endif
    );

    assign term_sel[k] = i_up ? term_up[k] : term_dn[k];
  end

  // Carry enables: digit k steps only when all lower digits sit at the terminal code.
  always_comb begin
    step    = '0;
    step[0] = i_en;
    for (int k = 1; k < DIGITS; k++) begin
      step[k] = step[k-1] & term_sel[k-1];
    end
  end

  // Full-chain rollover happens when an enabled step finds every digit terminal.
  always_comb begin
    wrap_d = i_en & ~i_clr & (&term_sel);
  end

  // Registered wrap pulse so it lines up with the wrapped count on o_cnt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign o_wrap = wrap_q;

`ifdef GREY_STATE_CHECK_EN
  assign o_err = |err;
`endif

endmodule

// File: tb/tb_grey_decade_chain.sv
// Self-checking bench for grey_decade_chain (DIGITS = 3).
// A decimal reference value is advanced alongside the DUT and encoded into
// Johnson codes every cycle; key points are also checked against
// hand-written code constants.
module tb_grey_decade_chain;

  localparam int DIGITS = 3;
  localparam int MODULUS = 1000;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_en;
  logic                  i_up;
  logic                  i_clr;
  logic [5*DIGITS-1:0]   o_cnt;
  logic                  o_wrap;
`ifdef GREY_STATE_CHECK_EN
  logic                  o_err;
`endif

  int   compared   = 0;
  int   mismatched = 0;
  int   expVal     = 0;
  logic expWrap    = 1'b0;

  // 10 ns clock
  always #5 i_clk = ~i_clk;

  grey_decade_chain #(.DIGITS(DIGITS)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_up   (i_up),
    .i_clr  (i_clr),
    .o_cnt  (o_cnt),
`ifdef GREY_STATE_CHECK_EN
    .o_wrap (o_wrap),
    .o_err  (o_err)
`else
    .o_wrap (o_wrap)
`endif
  );

  // Johnson code of one decimal digit
  function automatic logic [4:0] digitCode(input int d);
    logic [4:0] c;
    case (d)
      0: c = 5'b00000;
      1: c = 5'b00001;
      2: c = 5'b00011;
      3: c = 5'b00111;
      4: c = 5'b01111;
      5: c = 5'b11111;
      6: c = 5'b11110;
      7: c = 5'b11100;
      8: c = 5'b11000;
      default: c = 5'b10000;
    endcase
    return c;
  endfunction

  // Johnson encoding of a full decimal value
  function automatic logic [5*DIGITS-1:0] encode(input int v);
    logic [5*DIGITS-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[5*d +: 5] = digitCode(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the reference value and check the outputs
  task automatic applyStimulus(input logic rst, input logic en, input logic up,
                               input logic clr);
    i_rst = rst;
    i_en  = en;
    i_up  = up;
    i_clr = clr;
    @(posedge i_clk);
    #1;
    if (rst || clr) begin
      expVal  = 0;
      expWrap = 1'b0;
    end else if (en && up) begin
      expWrap = (expVal == MODULUS - 1);
      expVal  = (expVal + 1) % MODULUS;
    end else if (en) begin
      expWrap = (expVal == 0);
      expVal  = (expVal + MODULUS - 1) % MODULUS;
    end else begin
      expWrap = 1'b0;
    end
    checkOutput("cnt", 64'(o_cnt), 64'(encode(expVal)));
    checkOutput("wrap", 64'(o_wrap), 64'(expWrap));
  endtask

  initial begin
    $display("[TB] grey_decade_chain bench start");

    // Reset held two cycles with enable high
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_cnt", 64'(o_cnt), 64'd0);
    checkOutput("rst_wrap", 64'(o_wrap), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("first_step", 64'(o_cnt), 64'(15'b00000_00000_00001));

    // Up count to 999 then roll over
    for (int i = 0; i < 998; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("all9", 64'(o_cnt), 64'(15'b10000_10000_10000));
    checkOutput("all9_wrap", 64'(o_wrap), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_up_cnt", 64'(o_cnt), 64'd0);
    checkOutput("wrap_up", 64'(o_wrap), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_len", 64'(o_wrap), 64'd0);

    // Down count from 0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("down_999", 64'(o_cnt), 64'(15'b10000_10000_10000));
    checkOutput("wrap_dn", 64'(o_wrap), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("down_998", 64'(o_cnt), 64'(15'b10000_10000_11000));
    checkOutput("down_d0", 64'(o_cnt[4:0]), 64'(5'b11000));

    // Carry and direction change around 109/110
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 109; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("val_109", 64'(o_cnt), 64'(15'b00001_00000_10000));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("val_108", 64'(o_cnt), 64'(15'b00001_00000_11000));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("val_110_d1", 64'(o_cnt[9:5]), 64'(5'b00001));
    checkOutput("val_110_d2", 64'(o_cnt[14:10]), 64'(5'b00001));
    checkOutput("val_110_d0", 64'(o_cnt[4:0]), 64'(5'b00000));

    // Clear precedence over enable, then hold
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 457; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("val_457", 64'(o_cnt), 64'(15'b01111_11111_11100));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_cnt", 64'(o_cnt), 64'd0);
    checkOutput("clr_wrap", 64'(o_wrap), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_zero", 64'(o_cnt), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_3", 64'(o_cnt), 64'(15'b00000_00000_00111));

    // Reset in the middle of counting restarts from zero
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_mid", 64'(o_cnt), 64'd0);

`ifdef GREY_STATE_CHECK_EN
    // Upset on digit 1 is repaired on the next edge
    for (int i = 0; i < 457; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_upset", 64'(o_err), 64'd0);
    force dut.gen_digit[1].u_digit.q_q = 5'b01010;
    #1;
    release dut.gen_digit[1].u_digit.q_q;
    expVal = 407;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("upset_d1", 64'(o_cnt[9:5]), 64'(5'b00000));
    checkOutput("upset_d0", 64'(o_cnt[4:0]), 64'(5'b11100));
    checkOutput("upset_d2", 64'(o_cnt[14:10]), 64'(5'b01111));
    checkOutput("upset_err", 64'(o_err), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("upset_err_len", 64'(o_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
